mul_share_arbiter: RTL
======================

Name: mul_share_arbiter

Overview:
- Shares one signed×unsigned multiplier (33-bit signed × 10-bit unsigned → 36-bit, the HLS `mul_33s_10ns_36` operator) between N requesters.
- Arbitrates with round-robin or fixed priority, runs a 2-stage registered pipeline (operand register, product register) and returns each result tagged with the requester index.
- Full valid/ready backpressure end to end.
- Sits between the MHA dense/score units and a single DSP-mapped multiplier, so parallel lanes do not each need their own multiplier.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- A_W, 33, width of operand a, signed two's complement.
- B_W, 10, width of operand b, unsigned.
- P_W, 36, result width; the product is truncated to its low P_W bits.
- ID_W, 2, requester-index width, equal to clog2(N_REQ).

Ports:
- ap_clk  in  1  single clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- cfg_fixed_prio  in  1  1 = fixed priority (lowest index wins); 0 = round-robin.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  N_REQ*A_W  packed operand a; requester i occupies [i*A_W +: A_W].
- req_b  in  N_REQ*B_W  packed operand b; same packing.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accept.
- res_data  out  P_W  product, low P_W bits.
- res_id  out  ID_W  index of the requester that produced res_data.
- busy  out  1  high while either pipeline stage holds valid data.

Behaviour:
- Reset (async assert, sync release):
  - s1_valid = s2_valid = 0.
  - rr_ptr = 0.
  - res_valid = 0, res_data = 0, res_id = 0, busy = 0.
  - req_ready = 0 while ap_rst_n is low.
- Reset asserted mid-operation discards all in-flight data; no result is emitted for it.
- Stall rule:
  - stall2 = s2_valid & ~res_ready.
  - stall1 = s1_valid & stall2.
  - Stage 2 loads when ~stall2; stage 1 loads when ~stall1.
- Grant (combinational):
  - Granting is allowed when ~stall1.
  - Winner = first set bit of req_valid, searched from rr_ptr upward with wrap at N_REQ-1 → 0. With cfg_fixed_prio = 1 the search starts from index 0.
  - req_ready[winner] = 1 only when granting is allowed and some req_valid bit is set; all other bits are 0.
  - req_ready must not depend on req_valid of other requesters beyond the priority search.
- Accept: a transfer occurs when req_valid[i] & req_ready[i]. Stage 1 then captures a, b and id = i.
- Pointer: on accept, rr_ptr ← winner+1 (mod N_REQ). The pointer is also updated in fixed-priority mode, but not consulted there. No accept means no change.
- Stage 2 datapath:
  - Computes $signed(a) * $signed({1'b0, b}); full width is A_W+B_W+1.
  - Registers the low P_W bits as res_data, plus id.
  - res_valid = s2_valid.
- Latency: an accept in cycle t gives res_valid in cycle t+2 when there is no backpressure.
- Throughput: 1 result per cycle with res_ready held high.
- Output stability: res_data and res_id hold steady while res_valid & ~res_ready.
- Ordering: results leave in acceptance order; no reordering and no drops.
- Simultaneous events:
  - Stage 1 can refill in the same cycle that stage 2 drains into res.
  - A cfg_fixed_prio change takes effect on the next grant; data already in flight is unaffected.
- busy = s1_valid | s2_valid.

Decomposition:
- Shared package mul_share_pkg holds:
  - the A_W/B_W/P_W defaults;
  - the clog2 function;
  - a typedef for the stage-1 entry struct {a, b, id}.
- One natural sub-module, mul_share_rr_pick: rotate-and-priority-encode. Inputs are the request vector, the start pointer and the fixed flag; outputs are a one-hot grant and the index.
- The multiplier itself stays an inline expression in stage 2.

Test Plan:
- Single request, sign: req 2 only, a = -1, b = 1023, res_ready = 1 → one result 2 cycles after accept, res_data = 0xFFFFFFC01, res_id = 2.
- Wrap / truncation: a = 0x0FFFFFFFF, b = 1023 → res_data = 0xEFFFFFC01. Then a = -2^32, b = 1 → res_data = 0xF00000000.
- Round-robin fairness: all 4 req_valid held high for 8 accepts, rr_ptr starting at 0 → grant order 0,1,2,3,0,1,2,3; res_id follows the same order, 1 per cycle.
- Fixed priority: cfg_fixed_prio = 1, req 1 and req 3 held high → req 1 is granted every cycle and req 3 never; switch to 0 → alternation 3,1,3.
- Backpressure: stream 6 requests with res_ready low for cycles 3–7 → req_ready drops once both stages are full, res_data/res_id hold steady, and all 6 results emerge in order with no duplicates.
- Reset mid-flight: assert ap_rst_n = 0 with both stages valid → res_valid and busy go 0 immediately, req_ready goes 0. After release, the first grant goes to requester 0 and no stale result appears.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared types and defaults for the time-shared 33s x 10u multiplier arbiter.
// Holds the operand/result width defaults, a constant clog2 and the stage-1 entry type.
package mul_share_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int A_W_DEF   = 33;
  localparam int B_W_DEF   = 10;
  localparam int P_W_DEF   = 36;

  function automatic int clog2(input int value);
    for (int w = 0; w < 31; w++) begin
      if ((1 << w) >= value) return w;
    end
    return 31;
  endfunction

  localparam int ID_W_DEF = clog2(N_REQ_DEF);

  typedef struct packed {
    logic [A_W_DEF-1:0]  a;
    logic [B_W_DEF-1:0]  b;
    logic [ID_W_DEF-1:0] id;
  } s1_entry_t;

endpackage

// File: rtl/mul_share_rr_pick.sv
// Rotating priority encoder: finds the first set request at or after the start index,
// wrapping around; the fixed flag forces the search to begin at index 0.
module mul_share_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  start_i,
  input  logic             fixed_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             valid_o
);

  int   base;
  logic found;

  assign base = fixed_i ? 0 : int'(start_i);

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_i[(base + k) % N_REQ]) begin
        found                          = 1'b1;
        idx_o                          = ID_W'((base + k) % N_REQ);
        grant_o[(base + k) % N_REQ]    = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one signed x unsigned multiplier between N requesters: arbitration,
// operand register, product register, and tagged results under valid/ready flow control.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int A_W   = A_W_DEF,
  parameter int B_W   = B_W_DEF,
  parameter int P_W   = P_W_DEF,
  parameter int ID_W  = clog2(N_REQ)
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 cfg_fixed_prio,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*A_W-1:0] req_a,
  input  logic [N_REQ*B_W-1:0] req_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [P_W-1:0]       res_data,
  output logic [ID_W-1:0]      res_id,
  output logic                 busy
);

  logic             s1_valid_q;
  s1_entry_t        s1_q, s1_d;
  logic             s2_valid_q;
  logic [P_W-1:0]   res_data_q;
  logic [ID_W-1:0]  res_id_q;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [N_REQ-1:0] pick_grant;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_valid;
  logic             stall1, stall2, grant_en, accept;
  logic [P_W-1:0]   a_ext, b_ext, prod_low;

  mul_share_rr_pick #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req_i  (req_valid),
    .start_i(rr_ptr_q),
    .fixed_i(cfg_fixed_prio),
    .grant_o(pick_grant),
    .idx_o  (pick_idx),
    .valid_o(pick_valid)
  );

  assign stall2    = s2_valid_q & ~res_ready;
  assign stall1    = s1_valid_q & stall2;
  assign grant_en  = ~stall1 & ap_rst_n & pick_valid;
  assign req_ready = grant_en ? pick_grant : '0;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    s1_d.a   = req_a[int'(pick_idx)*A_W +: A_W];
    s1_d.b   = req_b[int'(pick_idx)*B_W +: B_W];
    s1_d.id  = pick_idx;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  // Low P_W bits of a modular product only need the operands extended to P_W,
  // which matches the full (A_W+B_W+1)-bit signed product truncated.
  assign a_ext    = {{(P_W-A_W){s1_q.a[A_W-1]}}, s1_q.a};
  assign b_ext    = {{(P_W-B_W){1'b0}}, s1_q.b};
  assign prod_low = a_ext * b_ext;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      res_data_q <= '0;
      res_id_q   <= '0;
      rr_ptr_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (!stall1) begin
        s1_valid_q <= accept;
        if (accept) s1_q <= s1_d;
      end
      if (!stall2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          res_data_q <= prod_low;
          res_id_q   <= s1_q.id;
        end
      end
    end
  end

  assign res_valid = s2_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = s1_valid_q | s2_valid_q;

endmodule
